// File: rtl/complex_vec_mult_ctrl_if.sv
// Bundle between the vector complex-multiply controller and its surroundings (loaders, multiplier, sink).
// Latency: none, wiring only.
// Backpressure: carried by in_valid/in_ready, mult_ready/mult_valid/mult_accept and out_valid/out_ready.
interface complex_vec_mult_ctrl_if #(
    parameter int BIT   = 32,
    parameter int LEN_W = 16
);
    // Vector control
    logic               start;
    logic [LEN_W-1:0]   len;
    logic               busy;
    logic               done;
    // Upstream operand stream
    logic               in_valid;
    logic               in_ready;
    logic [2*BIT-1:0]   in_a;
    logic [2*BIT-1:0]   in_b;
    // Multiplier handshake
    logic               mult_ready;
    logic [2*BIT-1:0]   mult_in_a;
    logic [2*BIT-1:0]   mult_in_b;
    logic               mult_valid;
    logic               mult_accept;
    logic [2*BIT-1:0]   mult_out_0;
    // Downstream product stream
    logic               out_valid;
    logic               out_ready;
    logic [2*BIT-1:0]   out_data;

    // Surrounding datapath view: drives requests, operands, multiplier results and sink ready.
    modport master (
        output start, len, in_valid, in_a, in_b, mult_valid, mult_out_0, out_ready,
        input  busy, done, in_ready, mult_ready, mult_in_a, mult_in_b, mult_accept, out_valid, out_data
    );

    // Controller view.
    modport slave (
        input  start, len, in_valid, in_a, in_b, mult_valid, mult_out_0, out_ready,
        output busy, done, in_ready, mult_ready, mult_in_a, mult_in_b, mult_accept, out_valid, out_data
    );
endinterface

// File: rtl/complex_vec_mult_ctrl.sv
// Streams LEN complex operand pairs through a single complex multiplier and forwards products in order.
// Latency: per element fetch + issue + multiplier latency + ack + drain (>=1) + output cycle; done 1 cycle after last output.
// Backpressure: out_ready low holds the product and blocks further fetches; in_ready is only high while fetching.
module complex_vec_mult_ctrl #(
    parameter int BIT   = 32,
    parameter int LEN_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    complex_vec_mult_ctrl_if.slave bus
);
    typedef logic [2*BIT-1:0] cplx_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT_RES,
        ACK,
        DRAIN,
        OUTPUT
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] remaining;
    logic             busy_r;
    logic             done_r;
    logic             in_ready_r;
    logic             mult_ready_r;
    logic             mult_accept_r;
    logic             out_valid_r;
    cplx_t            op_a;
    cplx_t            op_b;
    cplx_t            result;

    // Element sequencer: exactly one multiplier transaction outstanding, every output registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            remaining     <= '0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            in_ready_r    <= 1'b0;
            mult_ready_r  <= 1'b0;
            mult_accept_r <= 1'b0;
            out_valid_r   <= 1'b0;
            op_a          <= '0;
            op_b          <= '0;
            result        <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.len == '0) begin
                            // Empty vector completes immediately without ever going busy.
                            done_r <= 1'b1;
                        end else begin
                            remaining  <= bus.len;
                            busy_r     <= 1'b1;
                            in_ready_r <= 1'b1;
                            state      <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (bus.in_valid && in_ready_r) begin
                        op_a         <= bus.in_a;
                        op_b         <= bus.in_b;
                        in_ready_r   <= 1'b0;
                        mult_ready_r <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Request is a single-cycle pulse; a valid seen here is not ours yet.
                    mult_ready_r <= 1'b0;
                    state        <= WAIT_RES;
                end
                WAIT_RES: begin
                    if (bus.mult_valid) begin
                        result        <= bus.mult_out_0;
                        mult_accept_r <= 1'b1;
                        state         <= ACK;
                    end
                end
                ACK: begin
                    mult_accept_r <= 1'b0;
                    state         <= DRAIN;
                end
                DRAIN: begin
                    // Wait out the multiplier's valid so it is never mistaken for the next result.
                    if (!bus.mult_valid) begin
                        out_valid_r <= 1'b1;
                        state       <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        remaining   <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            done_r <= 1'b1;
                            busy_r <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            in_ready_r <= 1'b1;
                            state      <= FETCH;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.in_ready    = in_ready_r;
    assign bus.mult_ready  = mult_ready_r;
    assign bus.mult_in_a   = op_a;
    assign bus.mult_in_b   = op_b;
    assign bus.mult_accept = mult_accept_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_data    = result;
endmodule

// File: tb/tb_complex_vec_mult_ctrl.sv
// Directed bench for complex_vec_mult_ctrl with a behavioural Q16 complex multiplier attached.
// Latency: multiplier latency and post-accept valid lag are adjustable per scenario.
// Backpressure: the sink's out_ready is driven directly by the scenarios.
module tb_complex_vec_mult_ctrl;
    localparam int BIT   = 32;
    localparam int LEN_W = 16;

    logic clk = 1'b0;
    logic rst;

    complex_vec_mult_ctrl_if #(.BIT(BIT), .LEN_W(LEN_W)) bus ();

    complex_vec_mult_ctrl #(.BIT(BIT), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_in     = 0;
    int n_mreq   = 0;
    int n_macc   = 0;
    int n_done   = 0;
    int n_viol   = 0;
    bit in_fire  = 1'b0;

    logic [63:0] src_a [$];
    logic [63:0] src_b [$];
    logic [63:0] got   [$];

    int          lat = 1;
    int          lag = 0;
    logic [63:0] m_res;
    int          m_cnt;
    bit          m_pend;
    int          m_drop;

    logic [63:0] exp4 [4] = '{64'h00020000_00000000, 64'h00040000_00000000,
                              64'h00060000_00000000, 64'h00080000_00000000};
    logic [63:0] exp_bp [3] = '{64'h00000000_00010000, 64'h00000000_00020000,
                                64'h00000000_00030000};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] got_at(input int i);
        logic [63:0] v;
        v = 64'hx;
        if (i < got.size()) v = got[i];
        return v;
    endfunction

    // Q16 complex product {real, imag}.
    function automatic logic [63:0] cmul(input logic [63:0] a, input logic [63:0] b);
        longint ar, ai, br, bi, re, im;
        ar = $signed(a[63:32]);
        ai = $signed(a[31:0]);
        br = $signed(b[63:32]);
        bi = $signed(b[31:0]);
        re = (ar * br - ai * bi) >>> 16;
        im = (ar * bi + ai * br) >>> 16;
        return {re[31:0], im[31:0]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start(input logic [LEN_W-1:0] l);
        bus.start = 1'b1;
        bus.len   = l;
        tick;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int c = 0;
        while (bus.done !== 1'b1 && c < max) begin
            tick;
            c++;
        end
        check({tag, "_done"}, bus.done, 1);
        check({tag, "_busy_at_done"}, bus.busy, 0);
        tick;
        check({tag, "_done_one_cycle"}, bus.done, 0);
    endtask

    task automatic wait_out_valid(input string tag, input int max);
        int c = 0;
        while (bus.out_valid !== 1'b1 && c < max) begin
            tick;
            c++;
        end
        check({tag, "_out_valid"}, bus.out_valid, 1);
    endtask

    // Behavioural multiplier: result after lat cycles, valid held lag extra cycles past accept.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mult_valid <= 1'b0;
            bus.mult_out_0 <= '0;
            m_res          <= '0;
            m_cnt          <= 0;
            m_pend         <= 1'b0;
            m_drop         <= 0;
        end else begin
            if (bus.mult_ready) begin
                m_res  <= cmul(bus.mult_in_a, bus.mult_in_b);
                m_cnt  <= lat;
                m_pend <= 1'b1;
            end else if (m_pend) begin
                if (m_cnt == 0) begin
                    bus.mult_valid <= 1'b1;
                    bus.mult_out_0 <= m_res;
                    m_pend         <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
            if (bus.mult_valid && bus.mult_accept) begin
                if (lag == 0) bus.mult_valid <= 1'b0;
                else          m_drop <= lag;
            end else if (m_drop != 0) begin
                m_drop <= m_drop - 1;
                if (m_drop == 1) bus.mult_valid <= 1'b0;
            end
        end
    end

    // Mid-cycle monitor of handshakes and protocol violations.
    always @(negedge clk) begin
        in_fire = bus.in_valid && bus.in_ready;
        if (!rst) begin
            if (in_fire) n_in++;
            if (bus.mult_ready) n_mreq++;
            if (bus.mult_accept) n_macc++;
            if (bus.done) n_done++;
            if (bus.mult_valid && (bus.mult_ready || bus.out_valid)) n_viol++;
            if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
        end
    end

    // Upstream source fed from the src queues.
    initial begin
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        forever begin
            @(posedge clk);
            #1;
            if (in_fire && src_a.size() > 0) begin
                src_a.delete(0);
                src_b.delete(0);
            end
            if (src_a.size() > 0) begin
                bus.in_valid = 1'b1;
                bus.in_a     = src_a[0];
                bus.in_b     = src_b[0];
            end else begin
                bus.in_valid = 1'b0;
            end
        end
    end

    initial begin
        int b_in, b_mreq, b_macc, b_done, b_viol, bad, c;
        logic [63:0] held;

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_ctrl", {bus.busy, bus.done, bus.in_ready, bus.mult_ready, bus.mult_accept, bus.out_valid}, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_mult_in_a", bus.mult_in_a, 0);
        rst = 1'b0;
        tick;

        // Single element (1+2j)*(3-1j)
        bus.out_ready = 1'b1;
        got.delete();
        b_in = n_in; b_mreq = n_mreq; b_macc = n_macc;
        src_a.push_back(64'h00010000_00020000);
        src_b.push_back(64'h00030000_FFFF0000);
        pulse_start(1);
        check("single_busy", bus.busy, 1);
        wait_done("single", 100);
        check("single_count", got.size(), 1);
        check("single_data", got_at(0), 64'h00050000_00050000);
        check("single_mreq", n_mreq - b_mreq, 1);
        check("single_macc", n_macc - b_macc, 1);
        check("single_in", n_in - b_in, 1);

        // Vector of 4: (k+0j)*(2+0j)
        lat = 2;
        got.delete();
        b_in = n_in; b_done = n_done;
        for (int k = 1; k <= 4; k++) begin
            src_a.push_back({16'(k), 48'h0});
            src_b.push_back(64'h00020000_00000000);
        end
        pulse_start(4);
        wait_done("vec4", 300);
        check("vec4_count", got.size(), 4);
        for (int k = 0; k < 4; k++) check($sformatf("vec4_data%0d", k), got_at(k), exp4[k]);
        check("vec4_in", n_in - b_in, 4);
        check("vec4_done_once", n_done - b_done, 1);

        // Backpressure: element 2 held 10 cycles
        lat = 1;
        got.delete();
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            src_a.push_back({16'(k), 48'h0});
            src_b.push_back(64'h00000000_00010000);
        end
        pulse_start(3);
        wait_out_valid("bp_e1", 100);
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        wait_out_valid("bp_e2", 100);
        held = bus.out_data;
        bad = 0;
        repeat (10) begin
            tick;
            if (!(bus.out_valid === 1'b1 && bus.out_data === held &&
                  bus.in_ready === 1'b0 && bus.mult_ready === 1'b0)) bad++;
        end
        check("bp_hold_bad_cycles", bad, 0);
        check("bp_held_value", held, exp_bp[1]);
        bus.out_ready = 1'b1;
        wait_done("bp", 200);
        check("bp_count", got.size(), 3);
        for (int k = 0; k < 3; k++) check($sformatf("bp_data%0d", k), got_at(k), exp_bp[k]);

        // Lagging multiplier valid
        lag = 3;
        got.delete();
        b_mreq = n_mreq; b_macc = n_macc; b_viol = n_viol;
        src_a.push_back(64'h00010000_00000000);
        src_b.push_back(64'h00010000_00010000);
        src_a.push_back(64'h00020000_00000000);
        src_b.push_back(64'h00010000_00010000);
        pulse_start(2);
        wait_done("lag", 200);
        check("lag_count", got.size(), 2);
        check("lag_data0", got_at(0), 64'h00010000_00010000);
        check("lag_data1", got_at(1), 64'h00020000_00020000);
        check("lag_mreq", n_mreq - b_mreq, 2);
        check("lag_macc", n_macc - b_macc, 2);
        check("lag_violations", n_viol - b_viol, 0);
        lag = 0;

        // len == 0
        b_in = n_in; b_mreq = n_mreq;
        bus.start = 1'b1;
        bus.len   = '0;
        tick;
        bus.start = 1'b0;
        check("len0_done", bus.done, 1);
        check("len0_busy", bus.busy, 0);
        tick;
        check("len0_done_off", bus.done, 0);
        repeat (3) tick;
        check("len0_in", n_in - b_in, 0);
        check("len0_mreq", n_mreq - b_mreq, 0);

        // start while busy is ignored
        lat = 4;
        got.delete();
        b_in = n_in; b_done = n_done;
        src_a.push_back(64'h00010000_00000000);
        src_b.push_back(64'h00020000_00000000);
        src_a.push_back(64'h00030000_00000000);
        src_b.push_back(64'h00020000_00000000);
        pulse_start(2);
        repeat (2) tick;
        check("busy_restart_busy", bus.busy, 1);
        pulse_start(5);
        wait_done("busy_restart", 300);
        check("busy_restart_count", got.size(), 2);
        check("busy_restart_data0", got_at(0), 64'h00020000_00000000);
        check("busy_restart_data1", got_at(1), 64'h00060000_00000000);
        check("busy_restart_in", n_in - b_in, 2);
        check("busy_restart_done_once", n_done - b_done, 1);
        repeat (5) tick;
        check("busy_restart_idle", {bus.busy, bus.in_ready}, 0);

        // Reset while waiting for the multiplier
        lat = 20;
        got.delete();
        src_a.push_back(64'h00010000_00020000);
        src_b.push_back(64'h00030000_FFFF0000);
        pulse_start(1);
        c = 0;
        while (bus.mult_ready !== 1'b1 && c < 50) begin
            tick;
            c++;
        end
        check("rstw_mreq_seen", bus.mult_ready, 1);
        repeat (3) tick;
        check("rstw_pre_busy", bus.busy, 1);
        b_done = n_done;
        #1;
        rst = 1'b1;
        #1;
        check("rstw_ctrl", {bus.busy, bus.done, bus.in_ready, bus.mult_ready, bus.mult_accept, bus.out_valid}, 0);
        check("rstw_mult_in", {bus.mult_in_a[31:0], bus.mult_in_b[31:0]}, 0);
        check("rstw_out_data", bus.out_data, 0);
        repeat (3) tick;
        rst = 1'b0;
        tick;
        check("rstw_no_done", n_done - b_done, 0);
        lat = 1;
        src_a.delete();
        src_b.delete();
        got.delete();
        src_a.push_back(64'h00010000_00020000);
        src_b.push_back(64'h00030000_FFFF0000);
        pulse_start(1);
        wait_done("rstw_after", 100);
        check("rstw_after_count", got.size(), 1);
        check("rstw_after_data", got_at(0), 64'h00050000_00050000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/complex_vec_mult_ctrl.md
Name: complex_vec_mult_ctrl

Overview:
Initiator side of the complex multiplier handshake (mult_ready / mult_valid / mult_accept). It takes a vector of LEN complex operand pairs from an upstream valid/ready stream and issues each pair to one complex multiplier instance. It collects each product and forwards it on a downstream valid/ready stream, then pulses done. It sits between the vector loaders and the complex multiplier in the vector datapath.

Parameters:
BIT, 32, width of one real or imaginary part (Q16 fixed point); packed complex = {real, imag}, 2*BIT bits
LEN_W, 16, width of the vector-length input and element counter

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; latches len and begins a vector when idle
len  input  LEN_W  number of elements, sampled on start
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse after the last element is delivered
in_valid  input  1  upstream operand pair valid
in_ready  output  1  upstream handshake; transfer when in_valid && in_ready
in_a  input  2*BIT  operand A {real, imag}
in_b  input  2*BIT  operand B {real, imag}
mult_ready  output  1  request to multiplier, operands valid
mult_in_a  output  2*BIT  operand A to multiplier
mult_in_b  output  2*BIT  operand B to multiplier
mult_valid  input  1  multiplier result valid
mult_accept  output  1  result consumed
mult_out_0  input  2*BIT  multiplier result {real, imag}
out_valid  output  1  product valid downstream
out_ready  input  1  downstream handshake
out_data  output  2*BIT  product {real, imag}

Behaviour:
- Reset (async, any state): all outputs 0; state IDLE; counter 0; operand/result registers 0. A reset mid-vector abandons it, with no done pulse.
- All outputs are registered. The FSM has states IDLE, FETCH, ISSUE, WAIT_RES, ACK, DRAIN, OUTPUT.
- IDLE: busy=0. On start:
  - len==0: done=1 for one cycle next cycle; stay IDLE; busy stays 0.
  - Otherwise: latch len into remaining, set busy=1, go to FETCH.
  - start in any non-IDLE state is ignored.
- FETCH: in_ready=1. On in_valid, capture in_a/in_b into mult_in_a/mult_in_b, drop in_ready, go to ISSUE. At most one transfer per element.
- ISSUE: mult_ready=1 for exactly one cycle with operands stable, then go to WAIT_RES. The operands stay stable until the next FETCH capture.
- WAIT_RES: mult_ready=0. On mult_valid==1, capture mult_out_0 into out_data and go to ACK. There is no timeout.
- ACK: mult_accept=1 for exactly one cycle, then go to DRAIN.
- DRAIN: mult_accept=0. Wait until mult_valid==0, then go to OUTPUT.
  - The multiplier deasserts valid one cycle after seeing accept. DRAIN prevents a stale valid from being taken as the next result.
  - If mult_valid is already 0, DRAIN lasts one cycle.
- OUTPUT: out_valid=1 with out_data held. On out_ready, drop out_valid and decrement remaining.
  - remaining was 1: go to IDLE, pulse done, busy=0 (same cycle as done).
  - Otherwise: go to FETCH.
- Simultaneous events:
  - out_ready asserted before out_valid has no effect.
  - in_valid outside FETCH is not acknowledged (in_ready=0).
  - mult_valid while in ISSUE is ignored; results are only taken in WAIT_RES.
- Ordering: results leave in input order. Exactly one multiplier transaction is outstanding at a time.
- Data is passed through untouched. No arithmetic is done in this block; product width/format is the multiplier's (Q16, {real, imag}).
- Counter: LEN_W bits. len = 2^LEN_W-1 is supported, with no wrap before done.

Test Plan:
- Single element: len=1, in_a=0x00010000_00020000 (1+2j), in_b=0x00030000_FFFF0000 (3-1j), real multiplier attached -> one mult_ready pulse, one mult_accept pulse, out_data=0x00050000_00050000 (5+5j), then done pulse, busy=0.
- Vector of 4: (k+0j)*(2+0j) for k=1..4 with out_ready always 1 -> out_data 0x00020000_00000000, 0x00040000_00000000, 0x00060000_00000000, 0x00080000_00000000 in order; exactly 4 in_ready handshakes; done once.
- Backpressure: out_ready=0 for 10 cycles on element 2 -> out_valid and out_data held stable; in_ready stays 0; no new mult_ready until out_ready rises.
- Lagging valid: a behavioural multiplier holds mult_valid high 3 cycles after accept -> the controller stays in DRAIN; no duplicate output; the next mult_ready comes only after mult_valid=0.
- len=0 start -> done pulses the next cycle, no in_ready/mult_ready activity; start while busy -> ignored, count unchanged.
- rst asserted in WAIT_RES -> all outputs 0 immediately (asynchronously); no done; a new start with len=1 completes normally.
